// File: rtl/xadac_pkg.sv
// Shared type widths for the xadac execute interface and its units.
package xadac_pkg;
  typedef logic [3:0]   IdT;
  typedef logic [31:0]  InstrT;
  typedef logic [31:0]  XlenT;
  typedef logic [127:0] VectorT;
  typedef logic [31:0]  AddrT;
  typedef logic [15:0]  BeT;
endpackage

// File: rtl/xadac_ex_if.sv
// xadac execute interface: instruction request, response and the OBI memory channel.
// Handshakes: a transfer happens on any rising clk edge where valid (req/gnt side: req)
// and ready (gnt) are both high; the sender holds all fields stable until then.
interface xadac_ex_if;
  import xadac_pkg::*;

  logic   req_valid;
  logic   req_ready;
  IdT     req_id;
  InstrT  req_instr;
  XlenT   req_rs1;
  VectorT req_vs3;
  logic   req_rs1_read;
  logic   req_vs3_read;
  logic   req_rd_clobber;
  logic   req_vd_clobber;

  logic   resp_valid;
  logic   resp_ready;
  IdT     resp_id;
  XlenT   resp_rd;
  logic   resp_rd_write;
  VectorT resp_vd;
  logic   resp_vd_write;

  logic   obi_req;
  logic   obi_gnt;
  AddrT   obi_addr;
  logic   obi_we;
  BeT     obi_be;
  VectorT obi_wdata;
  IdT     obi_aid;
  logic   obi_rvalid;
  logic   obi_rready;
  VectorT obi_rdata;
  IdT     obi_rid;

  modport mst (
    output req_valid, req_id, req_instr, req_rs1, req_vs3, resp_ready,
           obi_gnt, obi_rvalid, obi_rdata, obi_rid,
    input  req_ready, req_rs1_read, req_vs3_read, req_rd_clobber, req_vd_clobber,
           resp_valid, resp_id, resp_rd, resp_rd_write, resp_vd, resp_vd_write,
           obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready
  );

  modport slv (
    input  req_valid, req_id, req_instr, req_rs1, req_vs3, resp_ready,
           obi_gnt, obi_rvalid, obi_rdata, obi_rid,
    output req_ready, req_rs1_read, req_vs3_read, req_rd_clobber, req_vd_clobber,
           resp_valid, resp_id, resp_rd, resp_rd_write, resp_vd, resp_vd_write,
           obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready
  );
endinterface

// File: rtl/xadac_vlsu.sv
// Vector load/store unit: one xadac instruction at a time becomes one OBI transaction.
// Optional post-increment loads/stores are enabled with XADAC_VLSU_POSTINC_EN.
module xadac_vlsu
  import xadac_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  xadac_ex_if.slv    ex,
  output logic [1:0] dbg_state_o
);
  localparam int unsigned VectorBytes = $bits(VectorT) / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;
  IdT     id_q, id_d;
  logic   we_q, we_d;
  XlenT   rs1_q, rs1_d;
  VectorT vs3_q, vs3_d;
  VectorT vd_q, vd_d;
  logic   vd_write_q, vd_write_d;
`ifdef XADAC_VLSU_POSTINC_EN
  XlenT   rd_q, rd_d;
  logic   rd_write_q, rd_write_d;
`endif

  logic dec_load, dec_store, dec_pi;

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_pi    = 1'b0;
    if (ex.req_instr[6:0] == 7'b0001011) begin
      case (ex.req_instr[14:12])
        3'b000: dec_load  = 1'b1;
        3'b001: dec_store = 1'b1;
`ifdef XADAC_VLSU_POSTINC_EN
        3'b010: begin dec_load  = 1'b1; dec_pi = 1'b1; end
        3'b011: begin dec_store = 1'b1; dec_pi = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  assign ex.req_rs1_read   = dec_load | dec_store;
  assign ex.req_vs3_read   = dec_store;
  assign ex.req_vd_clobber = dec_load;
  assign ex.req_rd_clobber = dec_pi;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    rs1_d      = rs1_q;
    vs3_d      = vs3_q;
    vd_d       = vd_q;
    vd_write_d = vd_write_q;
`ifdef XADAC_VLSU_POSTINC_EN
    rd_d       = rd_q;
    rd_write_d = rd_write_q;
`endif
    case (state_q)
      IDLE: begin
        if (ex.req_valid) begin
          id_d       = ex.req_id;
          we_d       = dec_store;
          rs1_d      = ex.req_rs1;
          vs3_d      = ex.req_vs3;
          vd_write_d = dec_load;
`ifdef XADAC_VLSU_POSTINC_EN
          rd_d       = dec_pi ? ex.req_rs1 + XlenT'(VectorBytes) : '0;
          rd_write_d = dec_pi;
`endif
          // Unsupported instructions skip memory and answer with no writes.
          state_d    = (dec_load || dec_store) ? REQ : RESP;
        end
      end
      REQ: begin
        if (ex.obi_gnt) state_d = RDATA;
      end
      RDATA: begin
        if (ex.obi_rvalid) begin
          if (vd_write_q) vd_d = ex.obi_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (ex.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      we_q       <= 1'b0;
      rs1_q      <= '0;
      vs3_q      <= '0;
      vd_q       <= '0;
      vd_write_q <= 1'b0;
`ifdef XADAC_VLSU_POSTINC_EN
      rd_q       <= '0;
      rd_write_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      rs1_q      <= rs1_d;
      vs3_q      <= vs3_d;
      vd_q       <= vd_d;
      vd_write_q <= vd_write_d;
`ifdef XADAC_VLSU_POSTINC_EN
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
`endif
    end
  end

  // Handshake outputs come straight from the state flop so reset clears them at once.
  assign ex.req_ready     = (state_q == IDLE);
  assign ex.obi_req       = (state_q == REQ);
  assign ex.obi_rready    = (state_q == RDATA);
  assign ex.resp_valid    = (state_q == RESP);
  assign ex.obi_addr      = rs1_q[$bits(AddrT)-1:0];
  assign ex.obi_we        = we_q;
  assign ex.obi_be        = '1;
  assign ex.obi_wdata     = vs3_q;
  assign ex.obi_aid       = id_q;
  assign ex.resp_id       = id_q;
  assign ex.resp_vd       = vd_q;
  assign ex.resp_vd_write = (state_q == RESP) && vd_write_q;
`ifdef XADAC_VLSU_POSTINC_EN
  assign ex.resp_rd       = rd_q;
  assign ex.resp_rd_write = (state_q == RESP) && rd_write_q;
`else
  assign ex.resp_rd       = '0;
  assign ex.resp_rd_write = 1'b0;
`endif

  assign dbg_state_o = state_q;

  logic unused_bits;
  assign unused_bits = ^{ex.req_instr[31:15], ex.req_instr[11:7], ex.obi_rid};
endmodule
